// File: rtl/dpram_pkg.sv
// Shared types, read-during-write mode constants and the byte-lane merge helper
// for the single-clock byte-enable dual-port RAM.
package dpram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Callers zero-extend into these widths and truncate the result back.
    localparam int unsigned MAX_DW = 256;
    localparam int unsigned MAX_NB = 256;
    localparam int unsigned IDX_W  = $clog2(MAX_DW);

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_word,
        input logic [MAX_DW-1:0] new_word,
        input logic [MAX_NB-1:0] be,
        input int unsigned       byte_width
    );
        logic [MAX_DW-1:0] result;
        result = old_word;
        for (int unsigned i = 0; i < MAX_DW; i++) begin
            if (be[IDX_W'(i / byte_width)]) begin
                result[IDX_W'(i)] = new_word[IDX_W'(i)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dpram_init_seq.sv
// Init sweep sequencer: walks every address once after reset, then holds READY.
module dpram_init_seq
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_init_done,
    output logic [ADDR_WIDTH-1:0] o_init_addr,
    output logic                  o_init_we
);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_init_done  = 1'b0;
        o_init_we    = 1'b0;
        case (r_state)
            INIT: begin
                o_init_we  = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_next = READY;
                end
            end
            READY: o_init_done = 1'b1;
        endcase
    end

    assign o_init_addr = r_cnt;

endmodule

// File: rtl/dpram_sync_be.sv
// Single-clock true dual-port RAM with byte-lane writes, read-valid strobes,
// fixed A-wins collision policy and a selectable read-during-write result.
module dpram_sync_be
    import dpram_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH = 5,
    parameter int unsigned              DATA_WIDTH = 8,
    parameter int unsigned              BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]    INIT_VALUE = '1,
    parameter int unsigned              RDW_MODE   = RDW_OLD
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               init_done,
    output logic                               collision,
    input  logic [DATA_WIDTH-1:0]              datain_A,
    input  logic [DATA_WIDTH-1:0]              datain_B,
    input  logic [ADDR_WIDTH-1:0]              addr_A,
    input  logic [ADDR_WIDTH-1:0]              addr_B,
    input  logic                               wr_enA,
    input  logic                               wr_enB,
    input  logic                               enA,
    input  logic                               enB,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_A,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_B,
    output logic [DATA_WIDTH-1:0]              dataout_A,
    output logic [DATA_WIDTH-1:0]              dataout_B,
    output logic                               valid_A,
    output logic                               valid_B
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0]            old_word,
        input logic [DATA_WIDTH-1:0]            new_word,
        input logic [DATA_WIDTH/BYTE_WIDTH-1:0] be
    );
        return DATA_WIDTH'(byte_merge(MAX_DW'(old_word), MAX_DW'(new_word), MAX_NB'(be),
                                      BYTE_WIDTH));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_init_done;
    logic                  w_init_we;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_a_rd, w_a_wr, w_b_rd, w_b_wr, w_same;
    logic [DATA_WIDTH-1:0] w_a_base, w_a_word, w_b_word, w_rd_a, w_rd_b;

    dpram_init_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_init_done (w_init_done),
        .o_init_addr (w_init_addr),
        .o_init_we   (w_init_we)
    );

    assign w_a_rd = w_init_done & ~enA & ~wr_enA;
    assign w_a_wr = w_init_done & ~enA &  wr_enA;
    assign w_b_rd = w_init_done & ~enB & ~wr_enB;
    assign w_b_wr = w_init_done & ~enB &  wr_enB;
    assign w_same = (addr_A == addr_B);

    // A merges on top of B's result so A's lanes win a same-address double write.
    assign w_b_word = merge(r_mem[addr_B], datain_B, be_B);
    assign w_a_base = (w_b_wr && w_same) ? w_b_word : r_mem[addr_A];
    assign w_a_word = merge(w_a_base, datain_A, be_A);

    assign w_rd_a = (RDW_MODE == RDW_NEW && w_b_wr && w_same) ? w_b_word : r_mem[addr_A];
    assign w_rd_b = (RDW_MODE == RDW_NEW && w_a_wr && w_same) ? w_a_word : r_mem[addr_B];

    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= INIT_VALUE;
        end else begin
            if (w_b_wr) begin
                r_mem[addr_B] <= w_b_word;
            end
            if (w_a_wr) begin
                r_mem[addr_A] <= w_a_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_A <= '0;
            dataout_B <= '0;
            valid_A   <= 1'b0;
            valid_B   <= 1'b0;
            collision <= 1'b0;
        end else begin
            valid_A   <= w_a_rd;
            valid_B   <= w_b_rd;
            collision <= w_init_done & ~enA & ~enB & w_same & (wr_enA | wr_enB);
            if (w_a_rd) begin
                dataout_A <= w_rd_a;
            end
            if (w_b_rd) begin
                dataout_B <= w_rd_b;
            end
        end
    end

    assign init_done = w_init_done;

endmodule
